// File: rtl/conv_frame_reassembler.sv
// Re-expands the valid-region CNN result stream into a full WIDTH x HEIGHT raster,
// with FILL_VALUE on the border. Optional macro CONV_REASM_CLAMP_EN saturates results.
module conv_frame_reassembler #(
  parameter int WIDTH       = 64,
  parameter int HEIGHT      = 64,
  parameter int WINDOW      = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int ACC_WIDTH   = 16,
  parameter logic [PIXEL_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ACC_WIDTH-1:0]   in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof,
  input  logic                   out_ready,
  output logic                   frame_err
);

  localparam int OUT_W = WIDTH - WINDOW + 1;
  localparam int OUT_H = HEIGHT - WINDOW + 1;
  localparam int PT    = (WINDOW - 1) / 2;
  localparam int PL    = PT;
  localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_BODY_LAST = XW'(PL + OUT_W - 1);
  localparam logic [YW-1:0] Y_BODY_LAST = YW'(PT + OUT_H - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   body;
  logic                   slot_free;
  logic                   load;
  logic                   accept;
  logic                   last_body;
  logic [PIXEL_WIDTH-1:0] conv_pixel;

  // Signed int compares keep the PL/PT = 0 case free of always-true unsigned tests.
  assign body      = (int'(x) >= PL) && (int'(x) < PL + OUT_W) &&
                     (int'(y) >= PT) && (int'(y) < PT + OUT_H);
  assign last_body = (x == X_BODY_LAST) && (y == Y_BODY_LAST);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && body && slot_free;
  assign load      = (state == RUN) && slot_free && (!body || in_valid);
  assign accept    = in_valid && in_ready;

`ifdef CONV_REASM_CLAMP_EN
  localparam logic [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'({PIXEL_WIDTH{1'b1}});
  assign conv_pixel = (in_data > PIX_MAX) ? {PIXEL_WIDTH{1'b1}} : in_data[PIXEL_WIDTH-1:0];
`else
  assign conv_pixel = in_data[PIXEL_WIDTH-1:0];
  generate
    if (ACC_WIDTH > PIXEL_WIDTH) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^in_data[ACC_WIDTH-1:PIXEL_WIDTH];
    end
  endgenerate
`endif

  // NOTE: all state below uses non-blocking assignment so every register samples
  // the pre-edge values of x/y/state; blocking here would skew markers by a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) state <= RUN;

      if (load) begin
        out_valid <= 1'b1;
        out_pixel <= body ? conv_pixel : FILL_VALUE;
        out_sof   <= (x == '0) && (y == '0);
        out_eol   <= (x == X_LAST);
        out_eof   <= (x == X_LAST) && (y == Y_LAST);
        if (x == X_LAST) begin
          x <= '0;
          if (y == Y_LAST) begin
            y     <= '0;
            state <= IDLE;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end else if (out_ready) begin
        // Pixel drained with nothing to replace it; payload is left as-is.
        out_valid <= 1'b0;
      end

      if (accept && (in_last != last_body)) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_frame_reassembler.sv
// Scoreboard bench for conv_frame_reassembler: a raster-level reference model
// predicts every output pixel; a negedge monitor pops and compares.
module tb_conv_frame_reassembler;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int WIN = 3;
  localparam int PW  = 8;
  localparam int AW  = 16;
  localparam logic [PW-1:0] FILL = 8'h00;
  localparam int OW  = W - WIN + 1;
  localparam int OH  = H - WIN + 1;
  localparam int PT  = (WIN - 1) / 2;
  localparam int NPIX = W * H;
  localparam int NRES = OW * OH;

  typedef logic [AW-1:0] res_q_t[$];
  typedef struct packed {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_pixel;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          out_ready;
  logic          frame_err;

  conv_frame_reassembler #(
    .WIDTH(W), .HEIGHT(H), .WINDOW(WIN), .PIXEL_WIDTH(PW), .ACC_WIDTH(AW), .FILL_VALUE(FILL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_ready(out_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  bit            mon_en = 1'b0;
  int            pix_cnt = 0;
  logic [PW-1:0] raster[NPIX];
  int            rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [PW-1:0] ref_conv(input logic [AW-1:0] v);
`ifdef CONV_REASM_CLAMP_EN
    return (int'(v) >= (1 << PW)) ? {PW{1'b1}} : v[PW-1:0];
`else
    return v[PW-1:0];
`endif
  endfunction

  // Reference: walk the full raster; interior takes the next result, border takes FILL.
  task automatic push_frame(input res_q_t res);
    int   k = 0;
    exp_t e;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        if (yy >= PT && yy < PT + OH && xx >= PT && xx < PT + OW) begin
          e.pix = ref_conv(res[k]);
          k++;
        end else begin
          e.pix = FILL;
        end
        e.sof = (xx == 0) && (yy == 0);
        e.eol = (xx == W - 1);
        e.eof = (xx == W - 1) && (yy == H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_frame(input res_q_t res, input bit gaps, input int bad_last);
    int idx = 0, run = 0, gap = 0, cyc = 0;
    bit acc;
    while (idx < res.size()) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data  = res[idx];
        in_last  = (idx == res.size() - 1) || (idx == bad_last);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (bad_last >= 0 && idx == bad_last - 1) check("frame_err_before", frame_err, 0);
        if (bad_last >= 0 && idx == bad_last)     check("frame_err_rise", frame_err, 1);
        idx++;
        if (gaps) begin
          run++;
          if (run == 5) begin
            run = 0;
            gap = 3;
          end
        end
      end
      cyc++;
      if (cyc > 5000) begin
        errors++;
        $display("FAIL drive_timeout: accepted %0d of %0d results", idx, res.size());
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic check_scenario1_raster();
    check("pix_count", pix_cnt, NPIX);
    check("pix_1_1", raster[1*W + 1], 1);
    check("pix_6_1", raster[1*W + 6], 6);
    check("pix_1_2", raster[2*W + 1], 7);
    check("pix_6_4", raster[4*W + 6], 24);
    check("pix_0_0", raster[0], FILL);
    check("pix_7_5", raster[NPIX - 1], FILL);
    check("frame_err_clean", frame_err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_pixel"}, out_pixel, 0);
    check({tag, "_markers"}, {out_sof, out_eol, out_eof}, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  // out_ready shaping: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  initial begin
    int phase = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin out_ready = pat[phase % 4]; phase++; end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every handshaken pixel and checks hold stability during stalls.
  initial begin
    bit           stall_pending = 1'b0;
    logic [PW+2:0] held = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending) begin
          check("hold_valid", out_valid, 1);
          check("hold_payload", {out_pixel, out_sof, out_eol, out_eof}, held);
        end
        stall_pending = out_valid && !out_ready;
        held = {out_pixel, out_sof, out_eol, out_eof};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: pixel 0x%0h with empty scoreboard", out_pixel);
          end else begin
            e = exp_q.pop_front();
            check("pixel", out_pixel, e.pix);
            check("markers", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
          end
          if (pix_cnt < NPIX) raster[pix_cnt] = out_pixel;
          pix_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_q_t seq;
    res_q_t rnd;
    bit     acc;
    int     outs;
    int     idx;

    for (int i = 1; i <= NRES; i++) seq.push_back(AW'(i));

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Scenario 1: free-flowing output
    pix_cnt = 0;
    push_frame(seq);
    drive_frame(seq, 1'b0, -1);
    wait_drain();
    check_scenario1_raster();

    // Scenario 2: out_ready 1,0,0,1 stalls
    rdy_mode = 1;
    pix_cnt = 0;
    push_frame(seq);
    drive_frame(seq, 1'b0, -1);
    wait_drain();
    check_scenario1_raster();

    // Scenario 3: input gaps of 3 cycles every 5 results
    rdy_mode = 0;
    pix_cnt = 0;
    push_frame(seq);
    drive_frame(seq, 1'b1, -1);
    wait_drain();
    check_scenario1_raster();

    // Scenario 4: wide random results (first is 0x0123), random stalls, early in_last
    rdy_mode = 2;
    rnd.push_back(16'h0123);
    for (int i = 1; i < NRES; i++) rnd.push_back(AW'($urandom_range(0, 16'hFFFF)));
    pix_cnt = 0;
    push_frame(rnd);
    drive_frame(rnd, 1'b1, 9);
    wait_drain();
`ifdef CONV_REASM_CLAMP_EN
    check("wide_value_conv", raster[1*W + 1], 8'hFF);
`else
    check("wide_value_conv", raster[1*W + 1], 8'h23);
`endif
    check("frame_err_sticky", frame_err, 1);

    // Scenario 5: reset after 20 output pixels, then a clean frame
    rdy_mode = 0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    outs = 0;
    idx = 0;
    while (outs < 20 && idx < NRES) begin
      in_valid = 1'b1;
      in_data  = seq[idx];
      in_last  = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) outs++;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("pre_reset_outputs", outs, 20);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    exp_q.delete();
    pix_cnt = 0;
    mon_en = 1'b1;
    push_frame(seq);
    drive_frame(seq, 1'b0, -1);
    wait_drain();
    check_scenario1_raster();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_reassembler.md
Name: conv_frame_reassembler

Overview:
- Back end of the CNN window path. Consumes the valid-region result stream produced from sliding windows: OUT_W x OUT_H results, where OUT_W = WIDTH-WINDOW+1 and OUT_H = HEIGHT-WINDOW+1.
- Re-emits a full WIDTH x HEIGHT row-major raster. Border positions carry FILL_VALUE; interior positions carry the results.
- Output is a valid/ready stream with sof/eol/eof markers. It feeds the next layer's window buffer or the frame writer.

Parameters:
- WIDTH, 64, output frame width in pixels
- HEIGHT, 64, output frame height in pixels
- WINDOW, 3, kernel size; sets border size. Legal range: 1..min(WIDTH,HEIGHT)
- PIXEL_WIDTH, 8, output pixel bits
- ACC_WIDTH, 16, input result bits; must be >= PIXEL_WIDTH
- FILL_VALUE, 0, border pixel value (PIXEL_WIDTH bits)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  result valid
- in_data  in  ACC_WIDTH  result value, unsigned
- in_last  in  1  marks the final result of a frame
- in_ready  out  1  block accepts a result this cycle
- out_valid  out  1  output pixel valid
- out_pixel  out  PIXEL_WIDTH  output pixel
- out_sof  out  1  pixel (0,0)
- out_eol  out  1  x == WIDTH-1
- out_eof  out  1  pixel (WIDTH-1, HEIGHT-1)
- out_ready  in  1  downstream accepts
- frame_err  out  1  sticky in_last mismatch flag

Behaviour:
- Padding split:
  - PT = PL = (WINDOW-1)/2 (integer division)
  - Bottom pad = right pad = WINDOW-1-PT
  - Body region: y in [PT, PT+OUT_H) and x in [PL, PL+OUT_W)
- Counters x in 0..WIDTH-1 and y in 0..HEIGHT-1 give the position of the next pixel to load into the output register.
- FSM states:
  - IDLE: output register empty, x=y=0. Moves to RUN on the first cycle in_valid=1. Nothing is consumed in that cycle.
  - RUN: one pixel loads into the output register per cycle when load = (!out_valid || out_ready).
- Pixel selection at each load:
  - Body position: pixel comes from in_data. Load additionally requires in_valid.
  - Border position: pixel is FILL_VALUE. Input is not consumed.
- in_ready = RUN && body position && (!out_valid || out_ready). A transfer occurs on in_valid && in_ready. in_ready is 0 in IDLE and at border positions.
- Latency: 1 cycle from input accept (or border load) to out_valid. Sustained rate is 1 pixel/clk when out_ready=1.
- Output hold: while out_valid && !out_ready, out_pixel and all flags are held stable.
  - out_valid drops only after a handshake with no new load.
  - A body position with in_valid=0 inserts a bubble: out_valid goes 0 after the pending pixel drains. x/y do not advance.
- Markers are registered with the pixel and describe that pixel's position.
- Counter advance on each load: x++. At x=WIDTH-1, x wraps to 0 and y++.
- Frame end: after the eof pixel loads, x=y=0 and the FSM returns to IDLE. No top border of the next frame is emitted until in_valid is seen again.
- Input width conversion without the optional feature: out_pixel = in_data[PIXEL_WIDTH-1:0] (truncation).
- frame_err is set (and stays set) on either condition:
  - accepted in_last=1 at a body position other than the last body position;
  - accepted result at the last body position with in_last=0.
  - Positioning is unaffected: no resync. Only rst clears frame_err.
- Reset values: out_valid=0, out_pixel=0, out_sof/eol/eof=0, in_ready=0, frame_err=0, state IDLE, x=y=0.
- Reset mid-frame: the partial frame is dropped and the next frame starts clean.
- WINDOW=1: no border, so output is a pass-through with markers.

Optional Feature:
- Macro: CONV_REASM_CLAMP_EN.
- Defined: in_data is saturated to the PIXEL_WIDTH range.
  - Values >= 2^PIXEL_WIDTH output as all-ones.
  - Smaller values pass unchanged.
- Not defined: truncation as above.
- Border and handshake behaviour are identical in both cases.

Test Plan:
- WIDTH=8, HEIGHT=6, WINDOW=3, FILL_VALUE=0, out_ready=1, 24 results with values 1..24 (in_last on 24). Required output:
  - 48 pixels;
  - row 0, row 5, column 0 and column 7 all 0;
  - pixel (1,1)=1, (6,1)=6, (1,2)=7, (6,4)=24;
  - sof only on the first pixel, eol on every 8th pixel, eof on the 48th pixel;
  - frame_err=0.
- Same frame with out_ready toggling 1,0,0,1 repeating: output sequence identical to scenario 1; out_pixel/markers stable across every stall.
- in_valid gaps of 3 cycles every 5 results: bubbles appear only at body positions; border pixels of the next row still stream out without input; output content unchanged.
- in_last asserted on result 10 of 24: frame_err rises after that accept and stays 1; eof still on pixel 48.
- in_data=0x0123 with PIXEL_WIDTH=8: out 0xFF with CONV_REASM_CLAMP_EN defined, 0x23 without it.
- rst asserted after 20 output pixels, then a full new frame: outputs go to 0 the cycle after reset; the new frame yields the exact scenario-1 sequence.
